hamming_secded_pipe: RTL and testbench

HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

---
 rtl/hamming_secded_pipe_if.sv | 31 +++
 rtl/hamming_secded_pipe.sv | 183 ++++++++++++++++++
 tb/tb_hamming_secded_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_pipe_if.sv
// Handshake bundle for hamming_secded_pipe: received codeword in, corrected
// payload plus error status out. The slave modport is the decoder side.
interface hamming_secded_pipe_if #(
  parameter int DATA_W = 11
);
  // Smallest P with 2^P >= DATA_W+P+1 over the supported range 4..57
  localparam int PAR_W = (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : 6;
  localparam int CW    = DATA_W + PAR_W + 1;

  logic [CW-1:0]     entrada;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] saida;
  logic [PAR_W-1:0]  err_pos;
  logic              corrigido;
  logic              incorrigivel;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output entrada, in_valid, out_ready,
    input  in_ready, saida, err_pos, corrigido, incorrigivel, out_valid
  );

  modport slave (
    input  entrada, in_valid, out_ready,
    output in_ready, saida, err_pos, corrigido, incorrigivel, out_valid
  );
endinterface

// File: rtl/hamming_secded_pipe.sv
// Two-stage stall-all SECDED Hamming decoder with saturating error counters.
// Stage 1 captures the codeword with its syndrome and overall parity check,
// stage 2 captures the corrected payload and the error classification.
// Define HAMMING_INJ_EN to add the inj_en / inj_pos_a / inj_pos_b ports that
// flip up to two codeword bits on the way into stage 1.
module hamming_secded_pipe #(
  parameter  int DATA_W = 11,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 : 6,
  localparam int CW     = DATA_W + PAR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hamming_secded_pipe_if.slave bus,
  input  logic                 clr_cnt,
`ifdef HAMMING_INJ_EN
  input  logic                 inj_en,
  input  logic [PAR_W:0]       inj_pos_a,
  input  logic [PAR_W:0]       inj_pos_b,
`endif
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_unc
);

  // Payload bit k lives at the k-th non-power-of-two position from 3 upward
  function automatic logic [DATA_W-1:0] extract_payload(input logic [CW-1:0] cw);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int i = 3; i < CW; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  logic              adv;
  logic [CW-1:0]     cw_in;
  logic [PAR_W-1:0]  syn_d;
  logic              chk_d;

  logic              vld_p1_q;
  logic [CW-1:0]     cw_p1_q;
  logic [PAR_W-1:0]  syn_p1_q;
  logic              chk_p1_q;

  logic [CW-1:0]     cw_fix;
  logic              corr_d;
  logic              unc_d;
  logic [DATA_W-1:0] saida_d;

  logic              vld_p2_q;
  logic [DATA_W-1:0] saida_q;
  logic [PAR_W-1:0]  err_pos_q;
  logic              corr_q;
  logic              unc_q;

  logic              xfer_out;
  logic [CNT_W-1:0]  cnt_corr_q;
  logic [CNT_W-1:0]  cnt_unc_q;

  // Whole pipe moves together whenever the output slot is free or draining
  assign adv          = bus.out_ready | ~vld_p2_q;
  assign bus.in_ready = adv;
  assign xfer_out     = vld_p2_q & bus.out_ready;

  // Optional bit flips on the incoming word; identical positions flip once
  always_comb begin
    cw_in = bus.entrada;
`ifdef HAMMING_INJ_EN
    if (inj_en) begin
      for (int i = 0; i < CW; i++) begin
        if (inj_pos_a == (PAR_W + 1)'(i) || inj_pos_b == (PAR_W + 1)'(i)) begin
          cw_in[i] = ~bus.entrada[i];
        end
      end
    end
`endif
  end

  // Syndrome is the XOR of the indices of all set bits; check is total parity
  always_comb begin
    syn_d = '0;
    for (int i = 1; i < CW; i++) begin
      if (cw_in[i]) begin
        syn_d = syn_d ^ PAR_W'(i);
      end
    end
    chk_d = ^cw_in;
  end

  // ---- stage 1 boundary: codeword, syndrome, overall check ----
  // Stage 1 valid bit follows the input handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= bus.in_valid;
    end
  end

  // Stage 1 data loads only on an accepted word
  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      cw_p1_q  <= cw_in;
      syn_p1_q <= syn_d;
      chk_p1_q <= chk_d;
    end
  end

  // Odd overall parity with an in-range syndrome is a single error at that
  // position; any other non-clean combination is uncorrectable and the word
  // is passed through untouched
  always_comb begin
    cw_fix = cw_p1_q;
    corr_d = 1'b0;
    unc_d  = 1'b0;
    if (chk_p1_q) begin
      for (int i = 0; i < CW; i++) begin
        if (syn_p1_q == PAR_W'(i)) begin
          cw_fix[i] = ~cw_p1_q[i];
          corr_d    = 1'b1;
        end
      end
      unc_d = ~corr_d;
    end else if (syn_p1_q != '0) begin
      unc_d = 1'b1;
    end
    saida_d = extract_payload(cw_fix);
  end

  // ---- stage 2 boundary: registered outputs ----
  // Output register holds while stalled and clears on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q  <= 1'b0;
      saida_q   <= '0;
      err_pos_q <= '0;
      corr_q    <= 1'b0;
      unc_q     <= 1'b0;
    end else if (adv) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        saida_q   <= saida_d;
        err_pos_q <= syn_p1_q;
        corr_q    <= corr_d;
        unc_q     <= unc_d;
      end
    end
  end

  // Corrected-word counter: clear beats increment, sticks at all ones
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_corr_q <= '0;
    end else if (xfer_out && corr_q && (cnt_corr_q != {CNT_W{1'b1}})) begin
      cnt_corr_q <= cnt_corr_q + 1'b1;
    end
  end

  // Uncorrectable-word counter: clear beats increment, sticks at all ones
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      cnt_unc_q <= '0;
    end else if (xfer_out && unc_q && (cnt_unc_q != {CNT_W{1'b1}})) begin
      cnt_unc_q <= cnt_unc_q + 1'b1;
    end
  end

  assign bus.out_valid    = vld_p2_q;
  assign bus.saida        = saida_q;
  assign bus.err_pos      = err_pos_q;
  assign bus.corrigido    = corr_q;
  assign bus.incorrigivel = unc_q;
  assign cnt_corr         = cnt_corr_q;
  assign cnt_unc          = cnt_unc_q;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Bench for hamming_secded_pipe (DATA_W=11). A 16-bit and a 2-bit counter
// instance see identical stimulus; outputs are scored against expectations
// derived from how each codeword was built (encode, then flip known bits).
module tb_hamming_secded_pipe;

  typedef struct packed {
    logic [10:0] data;
    logic [3:0]  pos;
    logic        corr;
    logic        unc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_cnt;
  logic [15:0] cnt_corr, cnt_unc;
  logic [1:0]  cnt_corr_s, cnt_unc_s;
`ifdef HAMMING_INJ_EN
  logic        inj_en;
  logic [4:0]  inj_pos_a, inj_pos_b;
`endif

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t cur_exp;
  int   m_corr, m_unc, s_corr, s_unc;
  logic rand_rdy = 1'b0;

  hamming_secded_pipe_if #(.DATA_W(11)) bus ();
  hamming_secded_pipe_if #(.DATA_W(11)) bus_s ();

  assign bus_s.entrada   = bus.entrada;
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.out_ready = bus.out_ready;

  always #5 clk = ~clk;

  hamming_secded_pipe #(.DATA_W(11), .CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clr_cnt   (clr_cnt),
`ifdef HAMMING_INJ_EN
    .inj_en    (inj_en),
    .inj_pos_a (inj_pos_a),
    .inj_pos_b (inj_pos_b),
`endif
    .cnt_corr  (cnt_corr),
    .cnt_unc   (cnt_unc)
  );

  hamming_secded_pipe #(.DATA_W(11), .CNT_W(2)) u_dut_sat (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_s),
    .clr_cnt   (clr_cnt),
`ifdef HAMMING_INJ_EN
    .inj_en    (inj_en),
    .inj_pos_a (inj_pos_a),
    .inj_pos_b (inj_pos_b),
`endif
    .cnt_corr  (cnt_corr_s),
    .cnt_unc   (cnt_unc_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  function automatic exp_t mk(input logic [10:0] d, input logic [3:0] p,
                              input logic c, input logic u);
    exp_t e;
    e.data = d; e.pos = p; e.corr = c; e.unc = u;
    return e;
  endfunction

  // Encode a random payload, then flip nflip distinct positions
  task automatic gen_word(input int nflip, output logic [15:0] cw, output exp_t e);
    logic [10:0] d;
    int          k, s, p1, p2;
    d  = 11'($urandom);
    cw = '0;
    k  = 0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    s = 0;
    for (int i = 1; i < 16; i++) if (cw[i]) s = s ^ i;
    for (int b = 0; b < 4; b++) cw[1 << b] = s[b];
    cw[0] = ^cw[15:1];
    e  = mk(d, 4'd0, 1'b0, 1'b0);
    p1 = int'($urandom_range(0, 15));
    p2 = (p1 + int'($urandom_range(1, 15))) % 16;
    if (nflip == 1) begin
      cw[p1] = ~cw[p1];
      e = mk(d, 4'(p1), 1'b1, 1'b0);
    end else if (nflip == 2) begin
      cw[p1] = ~cw[p1];
      cw[p2] = ~cw[p2];
      e = mk(extract(cw), 4'(p1 ^ p2), 1'b0, 1'b1);
    end
  endtask

  // Offer one word and hold it until accepted (bounded)
  task automatic send(input logic [15:0] cw, input exp_t e);
    int n;
    n = 0;
    bus.entrada  = cw;
    bus.in_valid = 1'b1;
    cur_exp      = e;
    @(negedge clk);
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Record expectation for every accepted word
  always @(posedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready) q.push_back(cur_exp);
  end

  // Score outputs (stalled words included) and track counter expectations
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      m_corr = 0; m_unc = 0; s_corr = 0; s_unc = 0;
    end else begin
      chk("cnt_corr", 32'(cnt_corr), 32'(m_corr));
      chk("cnt_unc", 32'(cnt_unc), 32'(m_unc));
      chk("cnt_corr_sat", 32'(cnt_corr_s), 32'(s_corr));
      chk("cnt_unc_sat", 32'(cnt_unc_s), 32'(s_unc));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = q[0];
          chk("saida", 32'(bus.saida), 32'(e.data));
          chk("err_pos", 32'(bus.err_pos), 32'(e.pos));
          chk("corrigido", 32'(bus.corrigido), 32'(e.corr));
          chk("incorrigivel", 32'(bus.incorrigivel), 32'(e.unc));
          chk("corrigido_sat", 32'(bus_s.corrigido), 32'(e.corr));
          if (bus.out_ready) begin
            void'(q.pop_front());
            if (e.corr) begin
              if (m_corr < 65535) m_corr++;
              if (s_corr < 3) s_corr++;
            end
            if (e.unc) begin
              if (m_unc < 65535) m_unc++;
              if (s_unc < 3) s_unc++;
            end
          end
        end
      end
      if (clr_cnt) begin
        m_corr = 0; m_unc = 0; s_corr = 0; s_unc = 0;
      end
    end
  end

  // Randomised output backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cw;
    exp_t        e;
    logic [15:0] w [3];
    exp_t        ew [3];

    reset         = 1'b1;
    clr_cnt       = 1'b0;
    bus.entrada   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;
`ifdef HAMMING_INJ_EN
    inj_en = 1'b0; inj_pos_a = '0; inj_pos_b = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_saida", 32'(bus.saida), 32'd0);
    chk("rst_err_pos", 32'(bus.err_pos), 32'd0);
    chk("rst_corrigido", 32'(bus.corrigido), 32'd0);
    chk("rst_incorrigivel", 32'(bus.incorrigivel), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_cnt_corr", 32'(cnt_corr), 32'd0);
    @(posedge clk);
    #1;

    // Directed words: clean, data-bit error, overall-parity error, double
    send(16'h0000, mk(11'd0, 4'd0, 1'b0, 1'b0));
    send(16'h0020, mk(11'd0, 4'd5, 1'b1, 1'b0));
    send(16'h0001, mk(11'd0, 4'd0, 1'b1, 1'b0));
    send(16'h0006, mk(11'd0, 4'd3, 1'b0, 1'b1));
    drain();
    chk("dir_cnt_corr", 32'(cnt_corr), 32'd2);
    chk("dir_cnt_unc", 32'(cnt_unc), 32'd1);

    // Backpressure: two words fill the pipe, the third is refused
    for (int i = 0; i < 3; i++) gen_word(i, w[i], ew[i]);
    bus.out_ready = 1'b0;
    send(w[0], ew[0]);
    send(w[1], ew[1]);
    bus.entrada  = w[2];
    bus.in_valid = 1'b1;
    cur_exp      = ew[2];
    @(negedge clk);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp_held_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(w[2], ew[2]);
    drain();

    // Saturation on the 2-bit instance, then clear on an output transfer
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_cnt_corr", 32'(cnt_corr), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      gen_word(1, cw, e);
      send(cw, e);
    end
    drain();
    chk("sat_cnt_corr", 32'(cnt_corr_s), 32'd3);
    chk("five_cnt_corr", 32'(cnt_corr), 32'd5);
    gen_word(1, cw, e);
    send(cw, e);
    @(posedge clk);
    #1;
    chk("sixth_out_valid", 32'(bus.out_valid), 32'd1);
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_win_corr_sat", 32'(cnt_corr_s), 32'd0);
    chk("clr_win_corr", 32'(cnt_corr), 32'd0);
    @(posedge clk);
    #1;

    // Random words with random gaps and random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      gen_word(int'($urandom_range(0, 2)), cw, e);
      send(cw, e);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    // Make counters non-zero, fill both stages, then reset
    gen_word(1, cw, e);
    send(cw, e);
    gen_word(2, cw, e);
    send(cw, e);
    drain();
    bus.out_ready = 1'b0;
    gen_word(1, cw, e);
    send(cw, e);
    gen_word(2, cw, e);
    send(cw, e);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstfull_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstfull_cnt_corr", 32'(cnt_corr), 32'd0);
    chk("rstfull_cnt_unc", 32'(cnt_unc), 32'd0);
    chk("rstfull_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

`ifdef HAMMING_INJ_EN
    inj_en = 1'b1;
    inj_pos_a = 5'd3; inj_pos_b = 5'd9;
    send(16'h0000, mk(11'h011, 4'd10, 1'b0, 1'b1));
    inj_pos_a = 5'd5; inj_pos_b = 5'd5;
    send(16'h0000, mk(11'd0, 4'd5, 1'b1, 1'b0));
    inj_pos_a = 5'd17; inj_pos_b = 5'd31;
    send(16'h0000, mk(11'd0, 4'd0, 1'b0, 1'b0));
    inj_en = 1'b0;
    drain();
`endif

    gen_word(0, cw, e);
    send(cw, e);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
